// File: rtl/lfsr_parallel.sv
// Parallel LFSR engine: advances a Galois or Fibonacci LFSR by DATA_WIDTH bit-steps per evaluation.
// Serves CRC, scrambler/descrambler and PRBS use; combinational results plus a registered copy.
module lfsr_parallel #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter int                    LFSR_FEED_FORWARD = 0,
  parameter int                    REVERSE           = 0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out,
  output logic [DATA_WIDTH-1:0] data_out_reg,
  output logic [LFSR_WIDTH-1:0] state_out_reg
);

  localparam int IO_W = LFSR_WIDTH + DATA_WIDTH;
  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");
  localparam logic [LFSR_WIDTH-1:0] GAL_TAPS = {LFSR_POLY[LFSR_WIDTH-1:1], 1'b0};
  // Bit j-1 of FIB_TAPS selects s[j-1] for polynomial term x^j.
  localparam logic [LFSR_WIDTH-1:0] FIB_TAPS = LFSR_POLY >> 1;

  // Reference bit-serial model; vectors are packed {state, data}.
  function automatic logic [IO_W-1:0] lfsr_eval(input logic [IO_W-1:0] in_vec);
    logic [LFSR_WIDTH-1:0] s, s_r;
    logic [DATA_WIDTH-1:0] d, d_r, o, o_r;
    logic                  b, t, ob;
    s   = in_vec[IO_W-1:DATA_WIDTH];
    d   = in_vec[DATA_WIDTH-1:0];
    s_r = '0;
    d_r = '0;
    o   = '0;
    o_r = '0;
    if (REVERSE != 0) begin
      for (int unsigned i = 0; i < LFSR_WIDTH; i++) s_r[i] = s[LFSR_WIDTH-1-i];
      for (int unsigned i = 0; i < DATA_WIDTH; i++) d_r[i] = d[DATA_WIDTH-1-i];
      s = s_r;
      d = d_r;
    end
    for (int unsigned n = 0; n < DATA_WIDTH; n++) begin
      b = d[DATA_WIDTH-1];
      d = d << 1;
      if (GALOIS) begin
        ob = s[LFSR_WIDTH-1] ^ b;
        t  = (LFSR_FEED_FORWARD != 0) ? s[LFSR_WIDTH-1] : ob;
        s  = {s[LFSR_WIDTH-2:0], t} ^ ({LFSR_WIDTH{t}} & GAL_TAPS);
      end else begin
        t  = s[LFSR_WIDTH-1] ^ (^(s & FIB_TAPS));
        ob = t ^ b;
        s  = {s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD != 0) ? b : ob};
      end
      o    = o << 1;
      o[0] = ob;
    end
    if (REVERSE != 0) begin
      for (int unsigned i = 0; i < LFSR_WIDTH; i++) s_r[i] = s[LFSR_WIDTH-1-i];
      for (int unsigned i = 0; i < DATA_WIDTH; i++) o_r[i] = o[DATA_WIDTH-1-i];
      s = s_r;
      o = o_r;
    end
    return {s, o};
  endfunction

  logic [IO_W-1:0] in_vec;
  logic [IO_W-1:0] out_vec;

  assign in_vec = {state_in, data_in};

  if (STYLE == "LOOP") begin : g_loop
    assign out_vec = lfsr_eval(in_vec);
  end else begin : g_reduction
    // The map is linear over GF(2), so each input bit contributes a fixed column
    // found by evaluating the model on that unit vector at elaboration time.
    logic [IO_W-1:0] term [IO_W];
    for (genvar i = 0; i < IO_W; i++) begin : g_col
      localparam logic [IO_W-1:0] COL = lfsr_eval({{(IO_W-1){1'b0}}, 1'b1} << i);
      assign term[i] = in_vec[i] ? COL : '0;
    end
    always_comb begin
      out_vec = '0;
      for (int unsigned i = 0; i < IO_W; i++) out_vec = out_vec ^ term[i];
    end
  end

  assign state_out = out_vec[IO_W-1:DATA_WIDTH];
  assign data_out  = out_vec[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] data_reg_d,  data_reg_q;
  logic [LFSR_WIDTH-1:0] state_reg_d, state_reg_q;

  always_comb begin
    data_reg_d  = data_out;
    state_reg_d = state_out;
    if (rst) begin
      data_reg_d  = '0;
      state_reg_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    data_reg_q  <= data_reg_d;
    state_reg_q <= state_reg_d;
  end

  assign data_out_reg  = data_reg_q;
  assign state_out_reg = state_reg_q;

endmodule

// File: tb/tb_lfsr_parallel.sv
// Directed self-checking bench for lfsr_parallel: CRC-32, PRBS31, scrambler round trip,
// small hand-worked vectors in every configuration, and the registered output path.
module tb_lfsr_parallel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // CRC-32 instances (reduction and loop styles)
  logic [7:0]  crc_di, crc_do, crcl_do, crc_dor, crcl_dor;
  logic [31:0] crc_si, crc_so, crcl_so, crc_sor, crcl_sor;

  lfsr_parallel #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("AUTO")
  ) u_crc (
    .clk(clk), .rst(rst), .data_in(crc_di), .state_in(crc_si),
    .data_out(crc_do), .state_out(crc_so), .data_out_reg(crc_dor), .state_out_reg(crc_sor)
  );

  lfsr_parallel #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
    .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8), .STYLE("LOOP")
  ) u_crc_loop (
    .clk(clk), .rst(rst), .data_in(crc_di), .state_in(crc_si),
    .data_out(crcl_do), .state_out(crcl_so), .data_out_reg(crcl_dor), .state_out_reg(crcl_sor)
  );

  // PRBS31 scrambler (defaults) and matching descrambler
  logic [7:0]  scr_di, scr_do, scr_dor, dsc_do, dsc_dor;
  logic [30:0] scr_si, scr_so, scr_sor, dsc_so, dsc_sor;

  lfsr_parallel u_scr (
    .clk(clk), .rst(rst), .data_in(scr_di), .state_in(scr_si),
    .data_out(scr_do), .state_out(scr_so), .data_out_reg(scr_dor), .state_out_reg(scr_sor)
  );

  lfsr_parallel #(.LFSR_FEED_FORWARD(1)) u_dsc (
    .clk(clk), .rst(rst), .data_in(scr_do), .state_in(scr_si),
    .data_out(dsc_do), .state_out(dsc_so), .data_out_reg(dsc_dor), .state_out_reg(dsc_sor)
  );

  // Small W=4, x^4+x+1 instances; index = {galois, feed_forward, reverse}
  logic [3:0] sm_di, sm_si;
  logic [3:0] sm_do [8];
  logic [3:0] sm_so [8];
  logic [3:0] sm_dor [8];
  logic [3:0] sm_sor [8];

  for (genvar c = 0; c < 8; c++) begin : g_small
    lfsr_parallel #(
      .LFSR_WIDTH(4), .LFSR_POLY(4'h3),
      .LFSR_CONFIG((c >= 4) ? "GALOIS" : "FIBONACCI"),
      .LFSR_FEED_FORWARD((c / 2) % 2), .REVERSE(c % 2),
      .DATA_WIDTH(4), .STYLE((c % 3 == 0) ? "LOOP" : "REDUCTION")
    ) u_small (
      .clk(clk), .rst(rst), .data_in(sm_di), .state_in(sm_si),
      .data_out(sm_do[c]), .state_out(sm_so[c]), .data_out_reg(sm_dor[c]), .state_out_reg(sm_sor[c])
    );
  end

  task automatic test_reset();
    rst = 1'b1;
    crc_di = 8'h5A;
    crc_si = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (crc_sor !== 32'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", crc_sor, 32'h0);
    end
    total++;
    if (crc_dor !== 8'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=%h", crc_dor, 8'h0);
    end
  endtask

  task automatic test_crc_byte();
    crc_si = 32'hFFFFFFFF;
    crc_di = 8'h00;
    #1;
    total++;
    if (crc_so !== 32'h2DFD1072) begin
      bad++;
      $display("FAIL crc_byte got=%h exp=%h", crc_so, 32'h2DFD1072);
    end
    total++;
    if (crcl_so !== 32'h2DFD1072) begin
      bad++;
      $display("FAIL crc_byte_loop got=%h exp=%h", crcl_so, 32'h2DFD1072);
    end
  endtask

  task automatic test_crc_string();
    logic [7:0]  msg [9];
    logic [31:0] st;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    st = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      crc_si = st;
      crc_di = msg[i];
      #1;
      st = crc_so;
    end
    total++;
    if (st !== 32'h340BC6D9) begin
      bad++;
      $display("FAIL crc_string got=%h exp=%h", st, 32'h340BC6D9);
    end
    total++;
    if (crcl_so !== 32'h340BC6D9) begin
      bad++;
      $display("FAIL crc_string_loop got=%h exp=%h", crcl_so, 32'h340BC6D9);
    end
  endtask

  task automatic test_prbs();
    scr_si = 31'h7FFFFFFF;
    scr_di = 8'h00;
    #1;
    total++;
    if (scr_so !== 31'h7FFFFF00) begin
      bad++;
      $display("FAIL prbs_state got=%h exp=%h", scr_so, 31'h7FFFFF00);
    end
    total++;
    if (scr_do !== 8'h00) begin
      bad++;
      $display("FAIL prbs_data got=%h exp=%h", scr_do, 8'h00);
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] orig;
    for (int i = 0; i < 20; i++) begin
      orig   = 8'($urandom);
      scr_di = orig;
      scr_si = 31'($urandom);
      #1;
      total++;
      if (dsc_do !== orig) begin
        bad++;
        $display("FAIL round_trip_data[%0d] got=%h exp=%h", i, dsc_do, orig);
      end
      total++;
      if (dsc_so !== scr_so) begin
        bad++;
        $display("FAIL round_trip_state[%0d] got=%h exp=%h", i, dsc_so, scr_so);
      end
    end
  endtask

  task automatic test_zero();
    sm_si = 4'h0;
    sm_di = 4'h0;
    #1;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (sm_do[c] !== 4'h0 || sm_so[c] !== 4'h0) begin
        bad++;
        $display("FAIL zero_cfg%0d got=%h/%h exp=0/0", c, sm_so[c], sm_do[c]);
      end
    end
  endtask

  task automatic test_small_vectors();
    sm_si = 4'b0001;
    sm_di = 4'b0000;
    #1;
    total++;
    if (sm_so[4] !== 4'b0011 || sm_do[4] !== 4'b0001) begin
      bad++;
      $display("FAIL galois_ff0 got=%b/%b exp=0011/0001", sm_so[4], sm_do[4]);
    end
    total++;
    if (sm_so[0] !== 4'b1110 || sm_do[0] !== 4'b1110) begin
      bad++;
      $display("FAIL fib_ff0 got=%b/%b exp=1110/1110", sm_so[0], sm_do[0]);
    end
    sm_di = 4'b1010;
    #1;
    total++;
    if (sm_so[6] !== 4'b0011 || sm_do[6] !== 4'b1011) begin
      bad++;
      $display("FAIL galois_ff1 got=%b/%b exp=0011/1011", sm_so[6], sm_do[6]);
    end
    total++;
    if (sm_so[2] !== 4'b1010 || sm_do[2] !== 4'b0110) begin
      bad++;
      $display("FAIL fib_ff1 got=%b/%b exp=1010/0110", sm_so[2], sm_do[2]);
    end
    sm_si = 4'b1000;
    sm_di = 4'b0000;
    #1;
    total++;
    if (sm_so[5] !== 4'b1100 || sm_do[5] !== 4'b1000) begin
      bad++;
      $display("FAIL galois_reverse got=%b/%b exp=1100/1000", sm_so[5], sm_do[5]);
    end
  endtask

  task automatic test_reg_path();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (crc_sor !== 32'h0) begin
      bad++;
      $display("FAIL reg_reset got=%h exp=%h", crc_sor, 32'h0);
    end
    rst    = 1'b0;
    crc_si = 32'hFFFFFFFF;
    crc_di = 8'h00;
    @(posedge clk);
    #1;
    total++;
    if (crc_sor !== 32'h2DFD1072) begin
      bad++;
      $display("FAIL reg_capture got=%h exp=%h", crc_sor, 32'h2DFD1072);
    end
    sm_si = 4'b0001;
    sm_di = 4'b0000;
    @(posedge clk);
    #1;
    total++;
    if (sm_sor[4] !== 4'b0011 || sm_dor[4] !== 4'b0001) begin
      bad++;
      $display("FAIL reg_small got=%b/%b exp=0011/0001", sm_sor[4], sm_dor[4]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (crc_sor !== 32'h0 || crc_dor !== 8'h0) begin
      bad++;
      $display("FAIL reg_midstream_reset got=%h/%h exp=0/0", crc_sor, crc_dor);
    end
    total++;
    if (crc_so !== 32'h2DFD1072) begin
      bad++;
      $display("FAIL comb_during_reset got=%h exp=%h", crc_so, 32'h2DFD1072);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (crc_sor !== 32'h2DFD1072) begin
      bad++;
      $display("FAIL reg_release got=%h exp=%h", crc_sor, 32'h2DFD1072);
    end
  endtask

  initial begin
    crc_di = '0;
    crc_si = '0;
    scr_di = '0;
    scr_si = '0;
    sm_di  = '0;
    sm_si  = '0;
    test_reset();
    rst = 1'b0;
    test_crc_byte();
    test_crc_string();
    test_prbs();
    test_round_trip();
    test_zero();
    test_small_vectors();
    test_reg_path();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
